// File: rtl/div_sched_pkg.sv
// rtl/div_sched_pkg.sv - shared state encoding and default latency for the divider scheduler
package div_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_LAT_DEFAULT = 34;

endpackage

// File: rtl/div_sched_oldest_pick.sv
// rtl/div_sched_oldest_pick.sv - combinational oldest-set-bit picker relative to a circular head index
module oldest_pick #(
    parameter int NCOMMIT  = 32,
    parameter int LNCOMMIT = 5
) (
    input  logic [NCOMMIT-1:0]  vector,
    input  logic [LNCOMMIT-1:0] head,
    output logic                valid,
    output logic [LNCOMMIT-1:0] index
);

    logic [LNCOMMIT-1:0] k;

    // Scanning downward leaves k at the smallest distance from head; the
    // LNCOMMIT-bit index sum wraps, which is the rotate.
    always_comb begin
        k = '0;
        for (int i = NCOMMIT - 1; i >= 0; i--) begin
            if (vector[LNCOMMIT'(i) + head]) begin
                k = LNCOMMIT'(i);
            end
        end
    end

    assign valid = |vector;
    assign index = head + k;

endmodule

// File: rtl/div_sched.sv
// rtl/div_sched.sv - issue/latency/kill scheduler for the shared divider; optional DIV_EARLY_OUT_EN
module div_sched
    import div_sched_pkg::*;
#(
    parameter int NCOMMIT  = 32,
    parameter int LNCOMMIT = 5,
    parameter int DIV_LAT  = DIV_LAT_DEFAULT,
    parameter int LDIV     = $clog2(DIV_LAT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NCOMMIT-1:0]  div_ready,
    input  logic [LNCOMMIT-1:0] commit_head,
    input  logic [NCOMMIT-1:0]  commit_kill,
    input  logic                wb_ack,
`ifdef DIV_EARLY_OUT_EN
    input  logic                div_early,
`endif
    output logic                div_enable,
    output logic [LNCOMMIT-1:0] div_addr,
    output logic                div_busy,
    output logic                div_abort,
    output logic                div_done,
    output logic [LNCOMMIT-1:0] div_done_addr
);

    localparam logic [LDIV-1:0] LAT_M1 = LDIV'(DIV_LAT - 1);

    div_state_t          state;
    logic [LDIV-1:0]     cnt;
    logic [NCOMMIT-1:0]  eff;
    logic                pick_valid;
    logic [LNCOMMIT-1:0] winner;
    logic                kill_hit;
    logic                issue;
    logic                finish;

    assign eff = div_ready & ~commit_kill;

    oldest_pick #(
        .NCOMMIT  (NCOMMIT),
        .LNCOMMIT (LNCOMMIT)
    ) u_pick (
        .vector (eff),
        .head   (commit_head),
        .valid  (pick_valid),
        .index  (winner)
    );

    assign kill_hit = (state != IDLE) && commit_kill[div_addr];

    // Issue is gated by reset so nothing strobes while held in reset; a kill
    // in DONE suppresses the back-to-back issue.
    assign issue = reset && pick_valid &&
                   ((state == IDLE) || ((state == DONE) && wb_ack && !kill_hit));

`ifdef DIV_EARLY_OUT_EN
    assign finish = (cnt == LDIV'(1)) || div_early;
`else
    assign finish = (cnt == LDIV'(1));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            div_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state    <= BUSY;
                        cnt      <= LAT_M1;
                        div_addr <= winner;
                    end
                end
                BUSY: begin
                    if (kill_hit) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (finish) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - LDIV'(1);
                    end
                end
                DONE: begin
                    if (kill_hit) begin
                        state <= IDLE;
                    end else if (issue) begin
                        state    <= BUSY;
                        cnt      <= LAT_M1;
                        div_addr <= winner;
                    end else if (wb_ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign div_enable    = issue;
    assign div_busy      = (state != IDLE);
    assign div_abort     = kill_hit;
    assign div_done      = (state == DONE);
    assign div_done_addr = (state == DONE) ? div_addr : '0;

endmodule

// File: tb/tb_div_sched.sv
// tb/tb_div_sched.sv - scoreboard bench for div_sched (covers DIV_EARLY_OUT_EN when defined)
module tb_div_sched;

    localparam int NC  = 32;
    localparam int LNC = 5;
    localparam int LAT = 34;

    logic            clk;
    logic            reset;
    logic [NC-1:0]   div_ready;
    logic [LNC-1:0]  commit_head;
    logic [NC-1:0]   commit_kill;
    logic            wb_ack;
`ifdef DIV_EARLY_OUT_EN
    logic            div_early;
`endif
    logic            div_enable;
    logic [LNC-1:0]  div_addr;
    logic            div_busy;
    logic            div_abort;
    logic            div_done;
    logic [LNC-1:0]  div_done_addr;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    div_sched dut (
        .clk           (clk),
        .reset         (reset),
        .div_ready     (div_ready),
        .commit_head   (commit_head),
        .commit_kill   (commit_kill),
        .wb_ack        (wb_ack),
`ifdef DIV_EARLY_OUT_EN
        .div_early     (div_early),
`endif
        .div_enable    (div_enable),
        .div_addr      (div_addr),
        .div_busy      (div_busy),
        .div_abort     (div_abort),
        .div_done      (div_done),
        .div_done_addr (div_done_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next negedge and let combinational outputs settle.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Returns cycles waited until div_done, or -1 on timeout.
    task automatic wait_done(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            n++;
            if (div_done) break;
            if (n > 200) begin
                n = -1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; div_ready = 32'h10; commit_head = '0; commit_kill = '0; wb_ack = 1'b0;
`ifdef DIV_EARLY_OUT_EN
        div_early = 1'b0;
`endif
        repeat (3) cyc();
        checks++;
        if ({div_enable, div_addr, div_busy, div_abort, div_done, div_done_addr} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%0b addr=%0d busy=%0b abort=%0b done=%0b daddr=%0d, want all 0",
                     div_enable, div_addr, div_busy, div_abort, div_done, div_done_addr);
        end
        @(negedge clk);
        div_ready = '0;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_basic_and_hold();
        int n;
        int exp;
        @(negedge clk);
        div_ready = 32'h10; commit_head = 5'd0;
        #1;
        checks++;
        if (div_enable !== 1'b1) begin
            errors++; $display("FAIL basic_enable: got %0b want 1", div_enable);
        end
        exp_q.push_back(4);
        @(negedge clk);
        div_ready = '0;
        #1;
        checks++;
        if (div_addr !== 5'd4 || div_busy !== 1'b1 || div_enable !== 1'b0) begin
            errors++; $display("FAIL basic_addr: got addr=%0d busy=%0b en=%0b want 4/1/0", div_addr, div_busy, div_enable);
        end
        wait_done(n);
        checks++;
        if (n < 0 || n + 1 !== LAT) begin
            errors++; $display("FAIL basic_latency: got %0d want %0d", n + 1, LAT);
        end
        exp = exp_q.pop_front();
        checks++;
        if (div_done_addr !== LNC'(exp)) begin
            errors++; $display("FAIL basic_done_addr: got %0d want %0d", div_done_addr, exp);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (div_done !== 1'b1) begin
                errors++; $display("FAIL done_hold: cycle %0d got %0b want 1", i, div_done);
            end
        end
        @(negedge clk);
        wb_ack = 1'b1; div_ready = 32'h100;
        #1;
        checks++;
        if (div_enable !== 1'b1 || div_done !== 1'b1) begin
            errors++; $display("FAIL b2b_enable: got en=%0b done=%0b want 1/1", div_enable, div_done);
        end
        exp_q.push_back(8);
        @(negedge clk);
        wb_ack = 1'b0; div_ready = '0;
        #1;
        checks++;
        if (div_done !== 1'b0 || div_addr !== 5'd8 || div_busy !== 1'b1) begin
            errors++; $display("FAIL b2b_next: got done=%0b addr=%0d busy=%0b want 0/8/1", div_done, div_addr, div_busy);
        end
        wait_done(n);
        checks++;
        if (n < 0 || n + 1 !== LAT) begin
            errors++; $display("FAIL b2b_latency: got %0d want %0d", n + 1, LAT);
        end
        exp = exp_q.pop_front();
        checks++;
        if (div_done_addr !== LNC'(exp)) begin
            errors++; $display("FAIL b2b_done_addr: got %0d want %0d", div_done_addr, exp);
        end
        @(negedge clk);
        wb_ack = 1'b1;
        #1;
        @(negedge clk);
        wb_ack = 1'b0;
        #1;
        checks++;
        if (div_busy !== 1'b0 || div_done !== 1'b0) begin
            errors++; $display("FAIL ack_idle: got busy=%0b done=%0b want 0/0", div_busy, div_done);
        end
    endtask

    task automatic test_pick();
        logic [LNC-1:0] heads[3] = '{5'd31, 5'd1, 5'd2};
        int exp;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            div_ready = 32'h8000_0003; commit_head = heads[t];
            #1;
            checks++;
            if (div_enable !== 1'b1) begin
                errors++; $display("FAIL pick_enable: head=%0d got %0b want 1", heads[t], div_enable);
            end
            exp_q.push_back((t == 1) ? 1 : 31);
            @(negedge clk);
            div_ready = '0;
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (div_addr !== LNC'(exp)) begin
                errors++; $display("FAIL pick_addr: head=%0d got %0d want %0d", heads[t], div_addr, exp);
            end
            @(negedge clk);
            commit_kill = 32'd1 << exp;
            #1;
            checks++;
            if (div_abort !== 1'b1) begin
                errors++; $display("FAIL pick_abort: got %0b want 1", div_abort);
            end
            @(negedge clk);
            commit_kill = '0;
            #1;
            checks++;
            if (div_busy !== 1'b0 || div_abort !== 1'b0) begin
                errors++; $display("FAIL pick_idle: got busy=%0b abort=%0b want 0/0", div_busy, div_abort);
            end
        end
        commit_head = '0;
    endtask

    task automatic test_kill();
        int kill_at[2] = '{10, LAT - 1};
        int seen;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            div_ready = 32'h10;
            #1;
            exp_q.push_back(4);
            for (int c = 1; c < kill_at[t]; c++) begin
                @(negedge clk);
                div_ready = '0;
                #1;
            end
            @(negedge clk);
            commit_kill = 32'h10;
            #1;
            checks++;
            if (div_abort !== 1'b1 || div_done !== 1'b0) begin
                errors++; $display("FAIL kill_abort: at %0d got abort=%0b done=%0b want 1/0", kill_at[t], div_abort, div_done);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
            commit_kill = '0;
            #1;
            checks++;
            if (div_abort !== 1'b0 || div_busy !== 1'b0) begin
                errors++; $display("FAIL kill_idle: at %0d got abort=%0b busy=%0b want 0/0", kill_at[t], div_abort, div_busy);
            end
            seen = 0;
            for (int c = 0; c < LAT + 4; c++) begin
                cyc();
                if (div_done) seen = 1;
            end
            checks++;
            if (seen !== 0) begin
                errors++; $display("FAIL kill_no_done: at %0d got done seen=%0d want 0", kill_at[t], seen);
            end
        end
    endtask

    task automatic test_done_kill_ack();
        int n;
        @(negedge clk);
        div_ready = 32'h10;
        #1;
        @(negedge clk);
        div_ready = '0;
        #1;
        wait_done(n);
        checks++;
        if (n < 0 || n + 1 !== LAT) begin
            errors++; $display("FAIL dk_latency: got %0d want %0d", n + 1, LAT);
        end
        @(negedge clk);
        wb_ack = 1'b1; commit_kill = 32'h10; div_ready = 32'h20;
        #1;
        checks++;
        if (div_abort !== 1'b1 || div_enable !== 1'b0) begin
            errors++; $display("FAIL dk_kill_wins: got abort=%0b en=%0b want 1/0", div_abort, div_enable);
        end
        @(negedge clk);
        wb_ack = 1'b0; commit_kill = '0;
        #1;
        checks++;
        if (div_enable !== 1'b1 || div_busy !== 1'b0) begin
            errors++; $display("FAIL dk_reissue: got en=%0b busy=%0b want 1/0", div_enable, div_busy);
        end
        exp_q.push_back(5);
        @(negedge clk);
        div_ready = '0;
        #1;
        checks++;
        if (div_addr !== LNC'(exp_q.pop_front())) begin
            errors++; $display("FAIL dk_addr: got %0d want 5", div_addr);
        end
    endtask

    task automatic test_reset_mid_op();
        // Entry 5 from the previous task is still in BUSY here.
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({div_enable, div_busy, div_abort, div_done, div_addr} !== 9'd0) begin
            errors++; $display("FAIL reset_mid: got en=%0b busy=%0b abort=%0b done=%0b addr=%0d want 0",
                               div_enable, div_busy, div_abort, div_done, div_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

`ifdef DIV_EARLY_OUT_EN
    task automatic test_early();
        @(negedge clk);
        div_ready = 32'h40;
        #1;
        @(negedge clk);
        div_ready = '0;
        #1;
        cyc();
        @(negedge clk);
        div_early = 1'b1;
        #1;
        checks++;
        if (div_done !== 1'b0) begin
            errors++; $display("FAIL early_pre: got %0b want 0", div_done);
        end
        @(negedge clk);
        div_early = 1'b0;
        #1;
        checks++;
        if (div_done !== 1'b1 || div_done_addr !== 5'd6) begin
            errors++; $display("FAIL early_done: got done=%0b addr=%0d want 1/6", div_done, div_done_addr);
        end
        @(negedge clk);
        wb_ack = 1'b1;
        #1;
        @(negedge clk);
        wb_ack = 1'b0;
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_and_hold();
        test_pick();
        test_kill();
        test_done_kill_ack();
        test_reset_mid_op();
`ifdef DIV_EARLY_OUT_EN
        test_early();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
